// File: rtl/fsm_seq_detect_pkg.sv
// Shared helpers and out-of-reset defaults for the programmable sequence detector.
package fsm_seq_detect_pkg;

  // Legacy behaviour: "101", length 3, overlapping.
  localparam logic [7:0] DEF_PAT = 8'b0000_0101;
  localparam int         DEF_LEN = 3;
  localparam bit         DEF_OVL = 1'b1;

  // Width needed to hold a length value 0..max_len.
  function automatic int clog2_len(input int max_len);
    return $clog2(max_len + 1);
  endfunction

  // Low mask of len ones. Callers truncate the result to MAX_LEN bits (MAX_LEN <= 32).
  function automatic logic [31:0] len_mask(input int len);
    if (len >= 32) return '1;
    return (32'd1 << len) - 32'd1;
  endfunction

endpackage

// File: rtl/seq_hist_shreg.sv
// History shift register (newest bit in bit 0) plus saturating fill counter.
module seq_hist_shreg #(
  parameter int W  = 7,
  parameter int FW = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          shift,
  input  logic          clear,
  input  logic          din,
  input  logic [FW-1:0] sat_max,
  output logic [W-1:0]  hist,
  output logic [FW-1:0] fill
);

  // Clear wins over shift; the oldest bit falls off the top.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hist <= '0;
      fill <= '0;
    end else if (clear) begin
      hist <= '0;
      fill <= '0;
    end else if (shift) begin
      hist <= W'({hist, din});
      fill <= (fill >= sat_max) ? sat_max : fill + FW'(1);
    end
  end

endmodule

// File: rtl/fsm_seq_detect.sv
// Runtime-programmable serial sequence detector with Mealy (out) and Moore (out_q)
// match outputs. Optional saturating match counter: define SEQ_DET_CNT_EN.
// The FILLING/ARMED control is implicit in the fill count; no separate state encoding.
module fsm_seq_detect
  import fsm_seq_detect_pkg::*;
#(
  parameter int               MAX_LEN = 8,
  parameter logic [MAX_LEN-1:0] RST_PAT = MAX_LEN'(DEF_PAT),
  parameter int               RST_LEN = DEF_LEN,
  parameter bit               RST_OVL = DEF_OVL,
`ifdef SEQ_DET_CNT_EN
  parameter int               CNT_W   = 8,
`endif
  localparam int              LEN_W   = clog2_len(MAX_LEN)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in,
  input  logic               in_valid,
  input  logic               cfg_load,
  input  logic [MAX_LEN-1:0] cfg_pat,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic               cfg_overlap,
  output logic               out,
`ifdef SEQ_DET_CNT_EN
  output logic [CNT_W-1:0]   match_cnt,
`endif
  output logic               out_q
);

  logic [MAX_LEN-1:0] pat_r;
  logic [LEN_W-1:0]   len_r;
  logic               ovl_r;
  logic [MAX_LEN-2:0] hist;
  logic [LEN_W-1:0]   fill;
  logic [LEN_W-1:0]   eff_len;
  logic [MAX_LEN-1:0] mask;
  logic [MAX_LEN-1:0] window;
  logic               armed;
  logic               match;
  logic               shift;
  logic               clr;

  // Config registers; a load takes effect from the following edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pat_r <= RST_PAT;
      len_r <= LEN_W'(RST_LEN);
      ovl_r <= RST_OVL;
    end else if (cfg_load) begin
      pat_r <= cfg_pat;
      len_r <= cfg_len;
      ovl_r <= cfg_overlap;
    end
  end

  // Comparator: the newest eff_len bits of {hist,in} against the pattern.
  always_comb begin
    eff_len = (len_r > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : len_r;
    mask    = MAX_LEN'(len_mask(int'(eff_len)));
    window  = {hist, in};
    armed   = (eff_len != '0) && (fill >= eff_len - LEN_W'(1));
    match   = in_valid && !cfg_load && armed && ((window & mask) == (pat_r & mask));
    shift   = in_valid && !cfg_load;
    // Non-overlap drops history after a hit; zeroing hist too is harmless since
    // fill gates every stale bit out of the comparison.
    clr     = cfg_load || (match && !ovl_r);
    out     = match;
  end

  seq_hist_shreg #(
    .W  (MAX_LEN - 1),
    .FW (LEN_W)
  ) u_hist (
    .clk     (clk),
    .reset   (reset),
    .shift   (shift),
    .clear   (clr),
    .din     (in),
    .sat_max (LEN_W'(MAX_LEN - 1)),
    .hist    (hist),
    .fill    (fill)
  );

  // Moore copy of the match, one cycle behind.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) out_q <= 1'b0;
    else        out_q <= match;
  end

`ifdef SEQ_DET_CNT_EN
  // Saturating match counter, cleared with the history on a config load.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                    match_cnt <= '0;
    else if (cfg_load)             match_cnt <= '0;
    else if (match && ~&match_cnt) match_cnt <= match_cnt + CNT_W'(1);
  end
`endif

endmodule

// File: tb/tb_fsm_seq_detect.sv
// Randomized + directed bench for fsm_seq_detect against a bit-list reference model.
module tb_fsm_seq_detect;
  localparam int MAXL = 8;
  localparam int CW   = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       din = 1'b0, vld = 1'b0, load = 1'b0, covl = 1'b0;
  logic [7:0] cpat = '0;
  logic [3:0] clen = '0;
  logic       out, out_q;
`ifdef SEQ_DET_CNT_EN
  logic [CW-1:0] match_cnt;
`endif

  int checks = 0;
  int errors = 0;

  // Reference model: received bits since last clear, plus config.
  bit         mq[$];
  logic [7:0] mpat;
  int         mlen;
  bit         movl;
  bit         mout_q;
  int         mcnt;

  always #5 clk = ~clk;

  fsm_seq_detect #(
    .MAX_LEN (MAXL)
`ifdef SEQ_DET_CNT_EN
    , .CNT_W (CW)
`endif
  ) dut (
    .clk         (clk),
    .reset       (rst_n),
    .in          (din),
    .in_valid    (vld),
    .cfg_load    (load),
    .cfg_pat     (cpat),
    .cfg_len     (clen),
    .cfg_overlap (covl),
    .out         (out),
`ifdef SEQ_DET_CNT_EN
    .match_cnt   (match_cnt),
`endif
    .out_q       (out_q)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    mpat = 8'b0000_0101; mlen = 3; movl = 1'b1; mout_q = 1'b0; mcnt = 0;
  endtask

  // Last bit received compares with pat[0], k bits earlier with pat[k].
  function automatic bit model_match(input bit b);
    int eff = (mlen > MAXL) ? MAXL : mlen;
    if (eff == 0) return 1'b0;
    if (mq.size() + 1 < eff) return 1'b0;
    for (int k = 0; k < eff; k++) begin
      bit rx = (k == 0) ? b : mq[mq.size() - k];
      if (rx != mpat[k]) return 1'b0;
    end
    return 1'b1;
  endfunction

  task automatic check_regs(input string tag);
    chk({tag, "_out_q"}, {31'b0, out_q}, {31'b0, mout_q});
`ifdef SEQ_DET_CNT_EN
    chk({tag, "_cnt"}, {28'b0, match_cnt}, mcnt);
`endif
  endtask

  // One clock: drive at negedge, check Mealy output, update model at posedge.
  task automatic step(input bit b, input bit v, input bit l,
                      input logic [7:0] p, input logic [3:0] ln, input bit o);
    bit m;
    @(negedge clk);
    din = b; vld = v; load = l; cpat = p; clen = ln; covl = o;
    m = (!l && v) ? model_match(b) : 1'b0;
    #1 chk("out", {31'b0, out}, {31'b0, m});
    @(posedge clk);
    if (l) begin
      mq.delete(); mpat = p; mlen = int'(ln); movl = o; mcnt = 0; mout_q = 1'b0;
    end else if (v) begin
      mq.push_back(b);
      if (m && !movl) mq.delete();
      while (mq.size() > MAXL - 1) void'(mq.pop_front());
      mout_q = m;
      if (m && mcnt < CMAX) mcnt++;
    end else begin
      mout_q = 1'b0;
    end
    #1 check_regs("q");
  endtask

  task automatic bit_in(input bit b);
    step(b, 1'b1, 1'b0, 8'h00, 4'd0, 1'b0);
  endtask

  task automatic cfg(input logic [7:0] p, input logic [3:0] ln, input bit o);
    step(1'b0, 1'b1, 1'b1, p, ln, o);
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 1'b0, 8'h00, 4'd0, 1'b0);
  endtask

  logic [9:0]  s10 = 10'b0110101101;   // stream 0,1,1,0,1,0,1,1,0,1 read from bit 9 down
  logic [7:0]  s8  = 8'b1100_1010;

  initial begin
    model_reset();
    #12;
    chk("rst_out", {31'b0, out}, 32'd0);
    check_regs("rst");
    @(negedge clk); rst_n = 1'b1;

    // Reset defaults: overlapping 101.
    for (int i = 9; i >= 0; i--) bit_in(s10[i]);
`ifdef SEQ_DET_CNT_EN
    chk("cnt_ovl", {28'b0, match_cnt}, 32'd3);
`endif

    // Non-overlapping 101.
    cfg(8'b101, 4'd3, 1'b0);
    for (int i = 9; i >= 0; i--) bit_in(s10[i]);
`ifdef SEQ_DET_CNT_EN
    chk("cnt_novl", {28'b0, match_cnt}, 32'd2);
`endif

    // Full-length pattern with a two-cycle valid gap.
    cfg(8'b1100_1010, 4'd8, 1'b1);
    for (int i = 7; i >= 0; i--) begin
      bit_in(s8[i]);
      if (i == 4) begin idle(); idle(); end
    end
    chk("long_last", {31'b0, out_q}, 32'd1);

    // Reload mid-match: history restarts.
    cfg(8'b101, 4'd3, 1'b1);
    bit_in(1'b1); bit_in(1'b0);
    cfg(8'b101, 4'd3, 1'b1);
    bit_in(1'b1); bit_in(1'b0); bit_in(1'b1);

    // len=0 never matches.
    cfg(8'h00, 4'd0, 1'b1);
    for (int i = 0; i < 20; i++) bit_in(1'($urandom));

    // Overlap with pattern 11: stream 111 hits on the 2nd and 3rd bits.
    cfg(8'b11, 4'd2, 1'b1);
    bit_in(1'b1); bit_in(1'b1); bit_in(1'b1);

    // Async reset mid-cycle while out is high under default config.
    cfg(8'b101, 4'd3, 1'b1);
    bit_in(1'b1); bit_in(1'b0);
    @(negedge clk);
    din = 1'b1; vld = 1'b1; load = 1'b0;
    #1 chk("pre_rst_out", {31'b0, out}, 32'd1);
    #1 rst_n = 1'b0;
    model_reset();
    #1 chk("arst_out", {31'b0, out}, 32'd0);
    check_regs("arst");
    #1 rst_n = 1'b1;
    vld = 1'b0;
    bit_in(1'b1); bit_in(1'b0); bit_in(1'b1);
    chk("post_rst_101", {31'b0, out_q}, 32'd1);

`ifdef SEQ_DET_CNT_EN
    // Counter saturation.
    cfg(8'b1, 4'd1, 1'b1);
    for (int i = 0; i < 20; i++) bit_in(1'b1);
    chk("cnt_sat", {28'b0, match_cnt}, CMAX);
`endif

    // Random traffic, short patterns favoured so matches occur.
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 24) == 0) begin
        logic [3:0] ln;
        ln = ($urandom_range(0, 5) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(1, 4));
        cfg(8'($urandom), ln, 1'($urandom));
      end else begin
        step(1'($urandom), ($urandom_range(0, 3) != 0), 1'b0, 8'h00, 4'd0, 1'b0);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
